// File: rtl/simple_reg_initiator.sv
// Bus initiator feeding a hash core's register slave: writes a block, starts the core, polls CTRL
// and reads back the digest on the last block. Optional poll timeout: SIMPLE_REG_INITIATOR_POLL_TIMEOUT_EN.
module simple_reg_initiator #(
  parameter int                   DataWidth   = 64,
  parameter int                   AddrWidth   = 32,
  parameter int                   DataBytes   = DataWidth >> 3,
  parameter int                   BlockWidth  = 512,
  parameter int                   DigestWidth = 256,
  parameter int                   ByteAlign   = 1,
  parameter logic [AddrWidth-1:0] BaseAddr    = '0,
  parameter int                   PollTimeout = 1024
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [BlockWidth-1:0]  block_i,
  input  logic                   block_last_i,
  input  logic                   block_valid_i,
  output logic                   block_ready_o,
  output logic [DigestWidth-1:0] digest_o,
  output logic                   digest_valid_o,
  input  logic                   digest_ready_i,
  output logic                   error_o,
  output logic [DataWidth-1:0]   reqdata_o,
  output logic [AddrWidth-1:0]   reqaddr_o,
  output logic                   reqvalid_o,
  output logic                   reqwrite_o,
  output logic [DataBytes-1:0]   reqstrobe_o,
  input  logic                   reqready_i,
  output logic                   rspready_o,
  input  logic                   rspvalid_i,
  input  logic [DataWidth-1:0]   rspdata_i,
  input  logic                   rsperror_i
);

  localparam int Step      = (ByteAlign != 0) ? DataWidth / 8 : DataWidth / 32;
  localparam int BlRegs    = BlockWidth / DataWidth;
  localparam int DiNumRegs = (DigestWidth + DataWidth - 1) / DataWidth;
  localparam int MaxRegs   = (BlRegs > DiNumRegs) ? BlRegs : DiNumRegs;
  localparam int CntW      = (MaxRegs > 1) ? $clog2(MaxRegs) : 1;

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StWrBlk  = 3'd1;
  localparam logic [2:0] StWrCtrl = 3'd2;
  localparam logic [2:0] StPoll   = 3'd3;
  localparam logic [2:0] StRdDig  = 3'd4;
  localparam logic [2:0] StOut    = 3'd5;
`ifdef SIMPLE_REG_INITIATOR_POLL_TIMEOUT_EN
  localparam logic [2:0] StWrRst  = 3'd6;
  localparam int         PollW    = $clog2(PollTimeout + 1);
`endif

  localparam logic PhIssue = 1'b0;
  localparam logic PhWait  = 1'b1;

  if (DataWidth < 32 || (DataWidth & (DataWidth - 1)) != 0 || AddrWidth < 12 ||
      DataBytes != DataWidth / 8 || (BlockWidth % DataWidth) != 0 ||
      BaseAddr[11:0] != 12'h000 || PollTimeout < 1) begin : g_param_check
    $error("simple_reg_initiator: illegal parameter set");
  end

  logic [2:0]                     state_r, state_s;
  logic                           phase_r, phase_s;
  logic [CntW-1:0]                cnt_r, cnt_s;
  logic [BlockWidth-1:0]          block_r, block_s;
  logic                           last_r, last_s;
  logic [DiNumRegs*DataWidth-1:0] digest_r, digest_s;
  logic                           error_r, error_s;
  logic                           block_ready_r, block_ready_s;
  logic                           digest_valid_r, digest_valid_s;
  logic                           reqvalid_r, reqvalid_s;
  logic                           reqwrite_r, reqwrite_s;
  logic                           rspready_r, rspready_s;
  logic [AddrWidth-1:0]           reqaddr_r, reqaddr_s;
  logic [DataWidth-1:0]           reqdata_r, reqdata_s;
  logic [DataBytes-1:0]           reqstrobe_r, reqstrobe_s;
`ifdef SIMPLE_REG_INITIATOR_POLL_TIMEOUT_EN
  logic [PollW-1:0]               poll_r, poll_s;
`endif

  function automatic logic is_bus(input logic [2:0] st);
    case (st)
      StWrBlk, StWrCtrl, StPoll, StRdDig: is_bus = 1'b1;
`ifdef SIMPLE_REG_INITIATOR_POLL_TIMEOUT_EN
      StWrRst: is_bus = 1'b1;
`endif
      default: is_bus = 1'b0;
    endcase
  endfunction

  function automatic logic is_write(input logic [2:0] st);
    case (st)
      StWrBlk, StWrCtrl: is_write = 1'b1;
`ifdef SIMPLE_REG_INITIATOR_POLL_TIMEOUT_EN
      StWrRst: is_write = 1'b1;
`endif
      default: is_write = 1'b0;
    endcase
  endfunction

  function automatic logic [AddrWidth-1:0] addr_of(input logic [2:0] st, input logic [CntW-1:0] c);
    logic [AddrWidth-1:0] off;
    off = AddrWidth'(c) * AddrWidth'(Step);
    case (st)
      StWrBlk:          addr_of = BaseAddr + AddrWidth'(12'h100) + off;
      StRdDig:          addr_of = BaseAddr + AddrWidth'(12'h200) + off;
      StWrCtrl, StPoll: addr_of = BaseAddr;
`ifdef SIMPLE_REG_INITIATOR_POLL_TIMEOUT_EN
      StWrRst:          addr_of = BaseAddr;
`endif
      default:          addr_of = {AddrWidth{1'b0}};
    endcase
  endfunction

  function automatic logic [DataWidth-1:0] data_of(input logic [2:0] st, input logic [CntW-1:0] c,
                                                   input logic [BlockWidth-1:0] blk, input logic lst);
    case (st)
      StWrBlk:  data_of = blk[c*DataWidth +: DataWidth];
      StWrCtrl: data_of = {{(DataWidth-6){1'b0}}, lst, 4'b0000, 1'b1};
`ifdef SIMPLE_REG_INITIATOR_POLL_TIMEOUT_EN
      StWrRst:  data_of = {{(DataWidth-2){1'b0}}, 2'b10};
`endif
      default:  data_of = {DataWidth{1'b0}};
    endcase
  endfunction

  // Next-state logic; every output is derived from the next state so it leaves a flop.
  always_comb begin
    state_s  = state_r;
    phase_s  = phase_r;
    cnt_s    = cnt_r;
    block_s  = block_r;
    last_s   = last_r;
    digest_s = digest_r;
    error_s  = 1'b0;
`ifdef SIMPLE_REG_INITIATOR_POLL_TIMEOUT_EN
    poll_s   = poll_r;
`endif
    case (state_r)
      StIdle: begin
        if (block_valid_i && block_ready_r) begin
          block_s = block_i;
          last_s  = block_last_i;
          cnt_s   = {CntW{1'b0}};
          phase_s = PhIssue;
          state_s = StWrBlk;
        end else begin
          state_s = StIdle;
        end
      end
      StOut: begin
        if (digest_ready_i) begin
          state_s = StIdle;
        end else begin
          state_s = StOut;
        end
      end
      default: begin
        if (!is_bus(state_r)) begin
          state_s = StIdle;
          phase_s = PhIssue;
        end else if (phase_r == PhIssue) begin
          phase_s = reqready_i ? PhWait : PhIssue;
        end else if (rsperror_i) begin
          // An error response abandons the block, whatever step it was in.
          error_s = 1'b1;
          state_s = StIdle;
          phase_s = PhIssue;
        end else if (rspvalid_i) begin
          phase_s = PhIssue;
          case (state_r)
            StWrBlk: begin
              if (cnt_r == CntW'(BlRegs - 1)) begin
                state_s = StWrCtrl;
                cnt_s   = {CntW{1'b0}};
              end else begin
                cnt_s = cnt_r + 1'b1;
              end
            end
            StWrCtrl: begin
              state_s = StPoll;
`ifdef SIMPLE_REG_INITIATOR_POLL_TIMEOUT_EN
              poll_s  = {PollW{1'b0}};
`endif
            end
            StPoll: begin
              if (rspdata_i[0]) begin
`ifdef SIMPLE_REG_INITIATOR_POLL_TIMEOUT_EN
                if (poll_r == PollW'(PollTimeout - 1)) begin
                  state_s = StWrRst;
                end else begin
                  poll_s = poll_r + 1'b1;
                end
`else
                state_s = StPoll;
`endif
              end else if (last_r) begin
                state_s = StRdDig;
                cnt_s   = {CntW{1'b0}};
              end else begin
                state_s = StIdle;
              end
            end
            StRdDig: begin
              digest_s[cnt_r*DataWidth +: DataWidth] = rspdata_i;
              if (cnt_r == CntW'(DiNumRegs - 1)) begin
                state_s = StOut;
              end else begin
                cnt_s = cnt_r + 1'b1;
              end
            end
`ifdef SIMPLE_REG_INITIATOR_POLL_TIMEOUT_EN
            StWrRst: begin
              error_s = 1'b1;
              state_s = StIdle;
            end
`endif
            default: state_s = StIdle;
          endcase
        end else begin
          phase_s = PhWait;
        end
      end
    endcase

    reqvalid_s     = is_bus(state_s) && (phase_s == PhIssue);
    rspready_s     = is_bus(state_s);
    reqwrite_s     = is_bus(state_s) && is_write(state_s);
    reqstrobe_s    = reqwrite_s ? {DataBytes{1'b1}} : {DataBytes{1'b0}};
    reqaddr_s      = addr_of(state_s, cnt_s);
    reqdata_s      = data_of(state_s, cnt_s, block_s, last_s);
    block_ready_s  = (state_s == StIdle);
    digest_valid_s = (state_s == StOut);
  end

  // State and output registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r        <= StIdle;
      phase_r        <= PhIssue;
      cnt_r          <= {CntW{1'b0}};
      block_r        <= {BlockWidth{1'b0}};
      last_r         <= 1'b0;
      digest_r       <= {(DiNumRegs*DataWidth){1'b0}};
      error_r        <= 1'b0;
      block_ready_r  <= 1'b0;
      digest_valid_r <= 1'b0;
      reqvalid_r     <= 1'b0;
      reqwrite_r     <= 1'b0;
      rspready_r     <= 1'b0;
      reqaddr_r      <= {AddrWidth{1'b0}};
      reqdata_r      <= {DataWidth{1'b0}};
      reqstrobe_r    <= {DataBytes{1'b0}};
`ifdef SIMPLE_REG_INITIATOR_POLL_TIMEOUT_EN
      poll_r         <= {PollW{1'b0}};
`endif
    end else begin
      state_r        <= state_s;
      phase_r        <= phase_s;
      cnt_r          <= cnt_s;
      block_r        <= block_s;
      last_r         <= last_s;
      digest_r       <= digest_s;
      error_r        <= error_s;
      block_ready_r  <= block_ready_s;
      digest_valid_r <= digest_valid_s;
      reqvalid_r     <= reqvalid_s;
      reqwrite_r     <= reqwrite_s;
      rspready_r     <= rspready_s;
      reqaddr_r      <= reqaddr_s;
      reqdata_r      <= reqdata_s;
      reqstrobe_r    <= reqstrobe_s;
`ifdef SIMPLE_REG_INITIATOR_POLL_TIMEOUT_EN
      poll_r         <= poll_s;
`endif
    end
  end

  assign block_ready_o  = block_ready_r;
  assign digest_o       = digest_r[DigestWidth-1:0];
  assign digest_valid_o = digest_valid_r;
  assign error_o        = error_r;
  assign reqdata_o      = reqdata_r;
  assign reqaddr_o      = reqaddr_r;
  assign reqvalid_o     = reqvalid_r;
  assign reqwrite_o     = reqwrite_r;
  assign reqstrobe_o    = reqstrobe_r;
  assign rspready_o     = rspready_r;

endmodule

// File: tb/tb_simple_reg_initiator.sv
// Self-checking bench for simple_reg_initiator: register-slave model plus a bus-transaction scoreboard.
module tb_simple_reg_initiator;

  typedef struct packed {
    logic        wr;
    logic [31:0] addr;
    logic [63:0] data;
    logic [7:0]  strb;
  } txn_t;

  logic         clk_i = 1'b0;
  logic         rst_ni;
  logic [511:0] block_i;
  logic         block_last_i, block_valid_i, block_ready_o;
  logic [255:0] digest_o;
  logic         digest_valid_o, digest_ready_i, error_o;
  logic [63:0]  reqdata_o;
  logic [31:0]  reqaddr_o;
  logic         reqvalid_o, reqwrite_o;
  logic [7:0]   reqstrobe_o;
  logic         reqready_i, rspready_o, rspvalid_i, rsperror_i;
  logic [63:0]  rspdata_i;

  int n_vec = 0;
  int n_err = 0;

  txn_t        exp_q[$];
  int          stall_left = 0, stall_seen = 0;
  bit          stall_changed = 1'b0;
  logic [31:0] stall_addr = 32'h0;
  bit          err_en = 1'b0;
  logic [31:0] err_addr = 32'h0;
  int          polls_to_clear = 1, polls_seen = 0, err_cycles = 0;
  bit          stuck = 1'b0;
  logic [63:0] dig_mem [4];
  logic [255:0] exp_digest;

  always #5 clk_i = ~clk_i;

  simple_reg_initiator #(.PollTimeout(4)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .block_i(block_i), .block_last_i(block_last_i), .block_valid_i(block_valid_i),
    .block_ready_o(block_ready_o),
    .digest_o(digest_o), .digest_valid_o(digest_valid_o), .digest_ready_i(digest_ready_i),
    .error_o(error_o),
    .reqdata_o(reqdata_o), .reqaddr_o(reqaddr_o), .reqvalid_o(reqvalid_o), .reqwrite_o(reqwrite_o),
    .reqstrobe_o(reqstrobe_o), .reqready_i(reqready_i),
    .rspready_o(rspready_o), .rspvalid_i(rspvalid_i), .rspdata_i(rspdata_i), .rsperror_i(rsperror_i)
  );

  // Register-slave model: accepts requests, answers one cycle later, scoreboards every accepted request.
  initial begin : slave
    txn_t o, e, pend_t;
    bit   pend;
    pend = 1'b0;
    pend_t = '0;
    reqready_i = 1'b1; rspvalid_i = 1'b0; rsperror_i = 1'b0; rspdata_i = 64'h0;
    forever begin
      @(negedge clk_i);
      rspvalid_i = 1'b0; rsperror_i = 1'b0; rspdata_i = 64'h0;
      if (error_o) err_cycles++;
      if (!rst_ni) begin
        pend = 1'b0;
        reqready_i = 1'b1;
      end else begin
        if (pend) begin
          pend = 1'b0;
          if (pend_t.wr) begin
            if (err_en && pend_t.addr == err_addr) rsperror_i = 1'b1;
            else rspvalid_i = 1'b1;
            if (pend_t.addr == 32'h0) polls_seen = 0;
          end else begin
            rspvalid_i = 1'b1;
            if (pend_t.addr == 32'h0) begin
              polls_seen++;
              rspdata_i = (stuck || polls_seen < polls_to_clear) ? 64'h1 : 64'h0;
            end else begin
              rspdata_i = dig_mem[pend_t.addr[4:3]];
            end
          end
        end
        if (reqvalid_o) begin
          if (stall_left > 0) begin
            reqready_i = 1'b0;
            if (stall_seen == 0) stall_addr = reqaddr_o;
            else if (reqaddr_o !== stall_addr) stall_changed = 1'b1;
            stall_left--;
            stall_seen++;
          end else begin
            reqready_i = 1'b1;
          end
          if (reqready_i) begin
            o = {reqwrite_o, reqaddr_o, reqdata_o, reqstrobe_o};
            n_vec++;
            if (exp_q.size() == 0) begin
              n_err++;
              $display("FAIL bus_txn: got wr=%0b addr=%h data=%h strb=%h, required no request",
                       o.wr, o.addr, o.data, o.strb);
            end else begin
              e = exp_q.pop_front();
              if (o !== e) begin
                n_err++;
                $display("FAIL bus_txn: got wr=%0b addr=%h data=%h strb=%h, required wr=%0b addr=%h data=%h strb=%h",
                         o.wr, o.addr, o.data, o.strb, e.wr, e.addr, e.data, e.strb);
              end
            end
            pend = 1'b1;
            pend_t = o;
          end
        end else begin
          reqready_i = 1'b1;
          if (stall_seen > 0 && stall_left > 0) stall_changed = 1'b1;
        end
      end
    end
  end

  function automatic void push_txn(input logic wr, input logic [31:0] a, input logic [63:0] d);
    exp_q.push_back({wr, a, d, wr ? 8'hFF : 8'h00});
  endfunction

  function automatic void push_words(input logic [511:0] b, input int n);
    for (int r = 0; r < n; r++) push_txn(1'b1, 32'h100 + 32'(r * 8), b[r*64 +: 64]);
  endfunction

  function automatic logic [511:0] rand_block();
    logic [511:0] b;
    for (int r = 0; r < 16; r++) b[r*32 +: 32] = $urandom;
    return b;
  endfunction

  task automatic send_block(input logic [511:0] b, input logic l, output bit ok);
    block_i = b; block_last_i = l; block_valid_i = 1'b1; ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      if (block_ready_o) ok = 1'b1;
      @(negedge clk_i);
    end
    block_valid_i = 1'b0;
  endtask

  task automatic wait_for(input int which, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 500 && !ok; i++) begin
      if ((which == 0 && block_ready_o) || (which == 1 && digest_valid_o)) ok = 1'b1;
      else @(negedge clk_i);
    end
  endtask

  task automatic test_reset();
    rst_ni = 1'b0; block_i = '0; block_last_i = 1'b0; block_valid_i = 1'b0; digest_ready_i = 1'b0;
    repeat (3) @(negedge clk_i);
    n_vec++;
    if ({reqvalid_o, reqwrite_o, rspready_o, block_ready_o, digest_valid_o, error_o} !== 6'b0) begin
      n_err++; $display("FAIL reset_ctrl: got %b required 000000",
                        {reqvalid_o, reqwrite_o, rspready_o, block_ready_o, digest_valid_o, error_o});
    end
    n_vec++;
    if ({reqaddr_o, reqdata_o, reqstrobe_o} !== 104'h0) begin
      n_err++; $display("FAIL reset_bus: got addr=%h data=%h strb=%h required all 0", reqaddr_o, reqdata_o, reqstrobe_o);
    end
    n_vec++;
    if (digest_o !== 256'h0) begin n_err++; $display("FAIL reset_digest: got %h required 0", digest_o); end
    rst_ni = 1'b1;
    repeat (2) @(negedge clk_i);
    n_vec++;
    if (block_ready_o !== 1'b1) begin n_err++; $display("FAIL idle_ready: got %b required 1", block_ready_o); end
  endtask

  task automatic test_block_nolast();
    logic [511:0] b; bit ok;
    b = rand_block(); polls_to_clear = 3; err_cycles = 0;
    push_words(b, 8); push_txn(1'b1, 32'h0, 64'h01);
    for (int i = 0; i < 3; i++) push_txn(1'b0, 32'h0, 64'h0);
    send_block(b, 1'b0, ok);
    n_vec++; if (ok !== 1'b1) begin n_err++; $display("FAIL nolast_accept: got %b required 1", ok); end
    wait_for(0, ok);
    n_vec++; if (ok !== 1'b1) begin n_err++; $display("FAIL nolast_done: got %b required 1", ok); end
    repeat (2) @(negedge clk_i);
    n_vec++; if (exp_q.size() !== 0) begin n_err++; $display("FAIL nolast_pending: got %0d required 0", exp_q.size()); end
    n_vec++; if (err_cycles !== 0) begin n_err++; $display("FAIL nolast_error: got %0d required 0", err_cycles); end
  endtask

  task automatic test_digest_last();
    logic [511:0] b; bit ok;
    b = rand_block(); polls_to_clear = 2;
    push_words(b, 8); push_txn(1'b1, 32'h0, 64'h21);
    for (int i = 0; i < 2; i++) push_txn(1'b0, 32'h0, 64'h0);
    for (int d = 0; d < 4; d++) push_txn(1'b0, 32'h200 + 32'(d * 8), 64'h0);
    send_block(b, 1'b1, ok);
    wait_for(1, ok);
    n_vec++; if (ok !== 1'b1) begin n_err++; $display("FAIL digest_valid: got %b required 1", ok); end
    n_vec++; if (digest_o !== exp_digest) begin n_err++; $display("FAIL digest_value: got %h required %h", digest_o, exp_digest); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      n_vec++;
      if ({digest_valid_o, block_ready_o} !== 2'b10 || digest_o !== exp_digest) begin
        n_err++; $display("FAIL digest_hold: got valid=%b ready=%b digest=%h required valid=1 ready=0 digest=%h",
                          digest_valid_o, block_ready_o, digest_o, exp_digest);
      end
    end
    digest_ready_i = 1'b1; @(negedge clk_i); digest_ready_i = 1'b0;
    n_vec++; if ({digest_valid_o, block_ready_o} !== 2'b01) begin
      n_err++; $display("FAIL digest_release: got valid=%b ready=%b required 0 1", digest_valid_o, block_ready_o);
    end
    n_vec++; if (exp_q.size() !== 0) begin n_err++; $display("FAIL digest_pending: got %0d required 0", exp_q.size()); end
  endtask

  task automatic test_bus_error();
    logic [511:0] b; bit ok;
    b = rand_block(); polls_to_clear = 1; err_cycles = 0; err_en = 1'b1; err_addr = 32'h118;
    push_words(b, 4);
    send_block(b, 1'b0, ok);
    wait_for(0, ok);
    n_vec++; if (ok !== 1'b1) begin n_err++; $display("FAIL err_idle: got %b required 1", ok); end
    repeat (3) @(negedge clk_i);
    n_vec++; if (err_cycles !== 1) begin n_err++; $display("FAIL err_pulse: got %0d cycles required 1", err_cycles); end
    n_vec++; if (exp_q.size() !== 0) begin n_err++; $display("FAIL err_pending: got %0d required 0", exp_q.size()); end
    err_en = 1'b0;
  endtask

  task automatic test_stall();
    logic [511:0] b; bit ok;
    b = rand_block(); polls_to_clear = 1; stall_seen = 0; stall_changed = 1'b0; stall_left = 4;
    push_words(b, 8); push_txn(1'b1, 32'h0, 64'h01); push_txn(1'b0, 32'h0, 64'h0);
    send_block(b, 1'b0, ok);
    wait_for(0, ok);
    repeat (2) @(negedge clk_i);
    n_vec++; if (stall_seen !== 4) begin n_err++; $display("FAIL stall_cycles: got %0d required 4", stall_seen); end
    n_vec++; if (stall_changed !== 1'b0 || stall_addr !== 32'h100) begin
      n_err++; $display("FAIL stall_hold: got changed=%b addr=%h required 0 00000100", stall_changed, stall_addr);
    end
    n_vec++; if (exp_q.size() !== 0) begin n_err++; $display("FAIL stall_pending: got %0d required 0", exp_q.size()); end
  endtask

  task automatic test_back_to_back();
    logic [511:0] b1, b2; bit ok;
    b1 = rand_block(); b2 = rand_block(); polls_to_clear = 1;
    push_words(b1, 8); push_txn(1'b1, 32'h0, 64'h21); push_txn(1'b0, 32'h0, 64'h0);
    for (int d = 0; d < 4; d++) push_txn(1'b0, 32'h200 + 32'(d * 8), 64'h0);
    push_words(b2, 8); push_txn(1'b1, 32'h0, 64'h01); push_txn(1'b0, 32'h0, 64'h0);
    send_block(b1, 1'b1, ok);
    wait_for(1, ok);
    block_i = b2; block_last_i = 1'b0; block_valid_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      n_vec++; if (block_ready_o !== 1'b0) begin n_err++; $display("FAIL b2b_blocked: got %b required 0", block_ready_o); end
    end
    digest_ready_i = 1'b1; @(negedge clk_i); digest_ready_i = 1'b0;
    send_block(b2, 1'b0, ok);
    n_vec++; if (ok !== 1'b1) begin n_err++; $display("FAIL b2b_accept: got %b required 1", ok); end
    wait_for(0, ok);
    repeat (2) @(negedge clk_i);
    n_vec++; if (exp_q.size() !== 0) begin n_err++; $display("FAIL b2b_pending: got %0d required 0", exp_q.size()); end
  endtask

`ifdef SIMPLE_REG_INITIATOR_POLL_TIMEOUT_EN
  task automatic test_poll_timeout();
    logic [511:0] b; bit ok;
    b = rand_block(); stuck = 1'b1; err_cycles = 0;
    push_words(b, 8); push_txn(1'b1, 32'h0, 64'h01);
    for (int i = 0; i < 4; i++) push_txn(1'b0, 32'h0, 64'h0);
    push_txn(1'b1, 32'h0, 64'h02);
    send_block(b, 1'b0, ok);
    wait_for(0, ok);
    repeat (3) @(negedge clk_i);
    n_vec++; if (err_cycles !== 1) begin n_err++; $display("FAIL timeout_pulse: got %0d cycles required 1", err_cycles); end
    n_vec++; if (exp_q.size() !== 0) begin n_err++; $display("FAIL timeout_pending: got %0d required 0", exp_q.size()); end
    stuck = 1'b0;
  endtask
`endif

  initial begin
    dig_mem[0] = 64'h1111111111111111; dig_mem[1] = 64'h2222222222222222;
    dig_mem[2] = 64'h3333333333333333; dig_mem[3] = 64'h4444444444444444;
    exp_digest = {64'h4444444444444444, 64'h3333333333333333, 64'h2222222222222222, 64'h1111111111111111};
    test_reset();
    test_block_nolast();
    test_digest_last();
    test_bus_error();
    test_stall();
    test_back_to_back();
`ifdef SIMPLE_REG_INITIATOR_POLL_TIMEOUT_EN
    test_poll_timeout();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
